// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
// Brute-force key search sequencer for an RC4 decryption core. Launches the core
// with a candidate key, snoops the D-memory write port while the core fills it, and
// on core completion either declares the key found or advances to the next key.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   go_i            start a search from KEY_MIN (accepted only when not busy)
//   key_o           candidate key driven to the core
//   core_start_o    one-cycle launch pulse for the first attempt
//   core_restart_o  one-cycle relaunch pulse for later attempts
//   core_done_i     core finished the current key
//   d_wren_i/d_data_i  snooped D-memory write port
//   busy_o, found_o, exhausted_o  search status
//   attempts_o      keys checked so far (only with RC4_KEY_SEARCH_ATTEMPTS_EN)
//
// Optional feature macro: RC4_KEY_SEARCH_ATTEMPTS_EN adds the attempts_o counter.
module rc4_key_search_ctrl #(
   parameter logic [23:0] KEY_MIN = 24'h000000,
   parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
   parameter int unsigned MSG_LEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go_i,
   output logic [23:0] key_o,
   output logic        core_start_o,
   output logic        core_restart_o,
   input  logic        core_done_i,
   input  logic        d_wren_i,
   input  logic [7:0]  d_data_i,
   output logic        busy_o,
   output logic        found_o,
   output logic        exhausted_o
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
   ,
   output logic [23:0] attempts_o
`endif
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StLaunch  = 3'd1;
   localparam logic [2:0] StRun     = 3'd2;
   localparam logic [2:0] StCheck   = 3'd3;
   localparam logic [2:0] StNext    = 3'd4;
   localparam logic [2:0] StFound   = 3'd5;
   localparam logic [2:0] StExhaust = 3'd6;

   localparam logic [8:0] MsgLenCnt = 9'(MSG_LEN);
   localparam logic [8:0] CntSat    = 9'd256;

   logic [2:0]  state_q, state_d;
   logic [23:0] key_q, key_d;
   logic [8:0]  cnt_q, cnt_d;
   logic        bad_q, bad_d;
   logic        first_q, first_d;
   logic        start_q, restart_q, busy_q, found_q, exhausted_q;
   logic        byte_ok;
   logic        go_accept;

   assign byte_ok   = ((d_data_i >= 8'h61) && (d_data_i <= 8'h7A)) || (d_data_i == 8'h20);
   assign go_accept = go_i && ((state_q == StIdle) || (state_q == StFound) ||
                               (state_q == StExhaust));

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      bad_d   = bad_q;
      first_d = first_q;
      case (state_q)
         StIdle, StFound, StExhaust: begin
            if (go_accept) begin
               key_d   = KEY_MIN;
               cnt_d   = '0;
               bad_d   = 1'b0;
               first_d = 1'b1;
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            first_d = 1'b0;
            state_d = StRun;
         end
         StRun: begin
            // A write coinciding with core_done_i still counts toward this key.
            if (d_wren_i) begin
               if (cnt_q != CntSat) cnt_d = cnt_q + 9'd1;
               if (!byte_ok) bad_d = 1'b1;
            end
            if (core_done_i) state_d = StCheck;
         end
         StCheck: begin
            state_d = (!bad_q && (cnt_q == MsgLenCnt)) ? StFound : StNext;
         end
         StNext: begin
            if (key_q == KEY_MAX) begin
               state_d = StExhaust;
            end else begin
               key_d   = key_q + 24'd1;
               cnt_d   = '0;
               bad_d   = 1'b0;
               state_d = StLaunch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Status and strobes are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         key_q       <= '0;
         cnt_q       <= '0;
         bad_q       <= 1'b0;
         first_q     <= 1'b0;
         start_q     <= 1'b0;
         restart_q   <= 1'b0;
         busy_q      <= 1'b0;
         found_q     <= 1'b0;
         exhausted_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         bad_q       <= bad_d;
         first_q     <= first_d;
         start_q     <= (state_d == StLaunch) && first_d;
         restart_q   <= (state_d == StLaunch) && !first_d;
         busy_q      <= (state_d == StLaunch) || (state_d == StRun) ||
                        (state_d == StCheck) || (state_d == StNext);
         found_q     <= (state_d == StFound);
         exhausted_q <= (state_d == StExhaust);
      end
   end

   assign key_o          = key_q;
   assign core_start_o   = start_q;
   assign core_restart_o = restart_q;
   assign busy_o         = busy_q;
   assign found_o        = found_q;
   assign exhausted_o    = exhausted_q;

`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
   logic [23:0] attempts_q, attempts_d;

   always_comb begin
      attempts_d = attempts_q;
      if (go_accept) begin
         attempts_d = '0;
      end else if ((state_q == StCheck) && (attempts_q != 24'hFFFFFF)) begin
         attempts_d = attempts_q + 24'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) attempts_q <= '0;
      else        attempts_q <= attempts_d;
   end

   assign attempts_o = attempts_q;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Testbench for rc4_key_search_ctrl: a core model replays a per-key byte plan,
// a reference model derives the expected launches and outcome from the plan, and a
// monitor compares the DUT's launches and final result against the queued expectations.
module tb_rc4_key_search_ctrl;

   localparam int KMIN = 0;
   localparam int KMAX = 7;
   localparam int MLEN = 32;
   localparam int NK   = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go_i = 1'b0;
   logic        core_done_i = 1'b0;
   logic        d_wren_i = 1'b0;
   logic [7:0]  d_data_i = 8'h00;
   logic [23:0] key_o;
   logic        core_start_o, core_restart_o, busy_o, found_o, exhausted_o;
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
   logic [23:0] attempts_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rc4_key_search_ctrl #(
      .KEY_MIN(24'(KMIN)),
      .KEY_MAX(24'(KMAX)),
      .MSG_LEN(MLEN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .go_i(go_i),
      .key_o(key_o),
      .core_start_o(core_start_o),
      .core_restart_o(core_restart_o),
      .core_done_i(core_done_i),
      .d_wren_i(d_wren_i),
      .d_data_i(d_data_i),
      .busy_o(busy_o),
      .found_o(found_o),
      .exhausted_o(exhausted_o)
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
      ,
      .attempts_o(attempts_o)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-key plan replayed by the core model.
   int         plan_len   [NK];
   int         plan_bad   [NK];  // position of the invalid byte, -1 for none
   logic [7:0] plan_badv  [NK];
   bit         plan_same  [NK];  // last byte written together with core_done_i
   bit         plan_stray [NK];  // invalid write while the controller is launching

   function automatic bit byte_ok(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
   endfunction

   function automatic logic [7:0] rand_valid();
      logic [7:0] b;
      do b = 8'($urandom); while (!byte_ok(b));
      return b;
   endfunction

   function automatic logic [7:0] rand_invalid();
      logic [7:0] b;
      do b = 8'($urandom); while (byte_ok(b));
      return b;
   endfunction

   function automatic bit key_good(input int k);
      return (plan_len[k] == MLEN) && (plan_bad[k] < 0);
   endfunction

   task automatic set_key(input int k, input int len, input int bad, input bit same);
      plan_len[k]   = len;
      plan_bad[k]   = bad;
      plan_badv[k]  = rand_invalid();
      plan_same[k]  = same;
      plan_stray[k] = 1'($urandom_range(0, 1));
   endtask

   task automatic all_bad();
      for (int k = 0; k < NK; k++) set_key(k, MLEN, int'($urandom_range(0, MLEN - 1)), 1'b0);
   endtask

   task automatic random_plan();
      int r;
      for (int k = 0; k < NK; k++) begin
         r = int'($urandom_range(0, 9));
         plan_len[k] = (r < 6) ? MLEN : ((r < 8) ? MLEN - 1 : ((r == 8) ? MLEN + 1 : 0));
         if (plan_len[k] == 0 || $urandom_range(0, 1) == 0) plan_bad[k] = -1;
         else plan_bad[k] = int'($urandom_range(0, plan_len[k] - 1));
         plan_badv[k]  = rand_invalid();
         plan_same[k]  = 1'($urandom_range(0, 1));
         plan_stray[k] = 1'($urandom_range(0, 1));
      end
   endtask

   typedef struct {
      int key;
      bit first;
   } launch_t;

   typedef struct {
      bit found;
      int key;
      int restarts;
      int attempts;
   } result_t;

   launch_t launch_q[$];
   result_t result_q[$];

   // Reference model: keys are tried in order until the first good one.
   task automatic expect_search();
      launch_t l;
      result_t r;
      int last;
      r.found = 1'b0;
      last = KMAX;
      for (int k = KMIN; k <= KMAX; k++) begin
         l.key = k;
         l.first = (k == KMIN);
         launch_q.push_back(l);
         if (key_good(k)) begin
            r.found = 1'b1;
            last = k;
            break;
         end
      end
      r.key = last;
      r.restarts = last - KMIN;
      r.attempts = last - KMIN + 1;
      result_q.push_back(r);
   endtask

   // Monitor: compares every launch and every final result against the queues.
   initial begin : monitor
      launch_t l;
      result_t r;
      bit fprev, eprev;
      int restarts;
      fprev = 1'b0;
      eprev = 1'b0;
      restarts = 0;
      forever begin
         @(negedge clk);
         if (core_start_o) restarts = 0;
         if (core_restart_o) restarts++;
         if (core_start_o || core_restart_o) begin
            if (launch_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL launch: unexpected launch of key %0h", key_o);
            end else begin
               l = launch_q.pop_front();
               check("launch_key", 32'(key_o), 32'(l.key));
               check("launch_kind", {30'd0, core_start_o, core_restart_o},
                     l.first ? 32'd2 : 32'd1);
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
               check("launch_attempts", 32'(attempts_o), 32'(l.key - KMIN));
`endif
            end
         end
         if ((found_o && !fprev) || (exhausted_o && !eprev)) begin
            if (result_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result: unexpected found=%0b exhausted=%0b", found_o, exhausted_o);
            end else begin
               r = result_q.pop_front();
               check("result_found", {31'd0, found_o}, {31'd0, r.found});
               check("result_exhausted", {31'd0, exhausted_o}, {31'd0, !r.found});
               check("result_key", 32'(key_o), 32'(r.key));
               check("result_busy", {31'd0, busy_o}, 32'd0);
               check("result_restarts", restarts, r.restarts);
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
               check("result_attempts", 32'(attempts_o), 32'(r.attempts));
`endif
            end
         end
         fprev = found_o;
         eprev = exhausted_o;
      end
   end

   task automatic step(output bit ab);
      @(negedge clk);
      ab = !rst_n;
   endtask

   task automatic idle_inputs();
      d_wren_i = 1'b0;
      core_done_i = 1'b0;
   endtask

   // Core model: called at the negedge of the launch cycle for key kin.
   task automatic drive_attempt(input int kin);
      int k, lat;
      bit ab;
      k = kin % NK;
      if (plan_stray[k]) begin
         d_wren_i = 1'b1;
         d_data_i = 8'h7B;
      end
      step(ab);
      d_wren_i = 1'b0;
      if (ab) begin idle_inputs(); return; end
      for (int i = 0; i < plan_len[k]; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            step(ab);
            if (ab) begin idle_inputs(); return; end
         end
         d_wren_i = 1'b1;
         d_data_i = (i == plan_bad[k]) ? plan_badv[k] : rand_valid();
         if (i == plan_len[k] - 1 && plan_same[k]) core_done_i = 1'b1;
         step(ab);
         idle_inputs();
         if (ab) return;
      end
      if (!(plan_same[k] && plan_len[k] > 0)) begin
         core_done_i = 1'b1;
         step(ab);
         core_done_i = 1'b0;
         if (ab) return;
      end
      check("key_stable", 32'(key_o), 32'(kin));
      lat = 1;
      while (!(found_o || exhausted_o || core_restart_o) && lat < 8) begin
         step(ab);
         if (ab) return;
         lat++;
      end
      check("done_latency", lat, key_good(k) ? 32'd2 : 32'd3);
   endtask

   initial begin : core_model
      @(negedge clk);
      forever begin
         if (rst_n && (core_start_o || core_restart_o)) drive_attempt(int'(key_o));
         else @(negedge clk);
      end
   end

   task automatic pulse_go();
      @(negedge clk);
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      check("go_start_pulse", {31'd0, core_start_o}, 32'd1);
      check("go_busy", {31'd0, busy_o}, 32'd1);
      @(negedge clk);
      check("start_pulse_width", {31'd0, core_start_o}, 32'd0);
   endtask

   // Waits for the monitor to consume the result; go_i is toggled while busy.
   task automatic wait_result(input string tag);
      for (int c = 0; c < 20000 && result_q.size() != 0; c++) begin
         @(negedge clk);
         go_i = busy_o && ($urandom_range(0, 29) == 0);
      end
      go_i = 1'b0;
      if (result_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout waiting for result", tag);
         result_q.delete();
         launch_q.delete();
      end
      check({tag, "_launches_left"}, launch_q.size(), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_search(input string tag);
      expect_search();
      pulse_go();
      wait_result(tag);
   endtask

   initial begin : main
      repeat (3) @(negedge clk);
      check("rst_key", 32'(key_o), 32'd0);
      check("rst_start", {31'd0, core_start_o}, 32'd0);
      check("rst_restart", {31'd0, core_restart_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_found", {31'd0, found_o}, 32'd0);
      check("rst_exhausted", {31'd0, exhausted_o}, 32'd0);
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
      check("rst_attempts", 32'(attempts_o), 32'd0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Keys 0,1 rejected, key 2 wins.
      all_bad();
      set_key(2, MLEN, -1, 1'b0);
      run_search("found_k2");

      // Every key rejected.
      all_bad();
      run_search("exhaust");

      // Short message rejected, next key wins.
      all_bad();
      set_key(0, MLEN - 1, -1, 1'b0);
      set_key(1, MLEN, -1, 1'b0);
      run_search("short_msg");

      // Last valid byte arrives with core_done_i.
      all_bad();
      set_key(0, MLEN, -1, 1'b1);
      run_search("same_cycle_ok");

      // Only invalid byte arrives with core_done_i.
      all_bad();
      set_key(0, MLEN, MLEN - 1, 1'b1);
      set_key(1, MLEN, -1, 1'b1);
      run_search("same_cycle_bad");

      // Overlong message must not alias MSG_LEN through the counter.
      all_bad();
      set_key(0, 512 + MLEN, -1, 1'b0);
      set_key(1, MLEN + 1, -1, 1'b0);
      set_key(2, MLEN, -1, 1'b0);
      run_search("saturate");

      // Winner at KEY_MIN+6.
      all_bad();
      set_key(6, MLEN, -1, 1'b0);
      run_search("found_k6");

      // Reset while running key 5.
      all_bad();
      expect_search();
      pulse_go();
      for (int c = 0; c < 5000 && key_o != 24'd5; c++) @(negedge clk);
      check("reach_key5", 32'(key_o), 32'd5);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_key", 32'(key_o), 32'd0);
      check("midrst_busy", {31'd0, busy_o}, 32'd0);
      check("midrst_start", {31'd0, core_start_o}, 32'd0);
      check("midrst_restart", {31'd0, core_restart_o}, 32'd0);
      check("midrst_found", {31'd0, found_o}, 32'd0);
      check("midrst_exhausted", {31'd0, exhausted_o}, 32'd0);
`ifdef RC4_KEY_SEARCH_ATTEMPTS_EN
      check("midrst_attempts", 32'(attempts_o), 32'd0);
`endif
      launch_q.delete();
      result_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      all_bad();
      set_key(1, MLEN, -1, 1'b0);
      run_search("after_reset");

      // Randomised searches.
      for (int n = 0; n < 12; n++) begin
         random_plan();
         run_search("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
